lfsr_noise_stream: RTL and testbench

//  Parametrised Fibonacci XNOR-LFSR pseudo-random word generator for the synth voice path (noise oscillator, dither).

---
 rtl/lfsr_noise_stream.sv | 150 +++++++++++++++
 tb/tb_lfsr_noise_stream.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_noise_stream.sv
// Fibonacci XNOR-LFSR noise word generator with valid/ready output,
// runtime seed load and lock-up recovery.
module lfsr_noise_stream #(
   parameter int unsigned          LFSR_BITS       = 31,
   parameter int unsigned          OUT_BITS        = 16,
   parameter int unsigned          SHIFTS_PER_WORD = 1,
   parameter logic [LFSR_BITS-1:0] SEED            = '0
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 enable,
   input  logic                 seed_load,
   input  logic [LFSR_BITS-1:0] seed_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [OUT_BITS-1:0]  out_data,
   output logic                 lockup_fix
);

   typedef enum logic {
      RUN,
      PRESENT
   } state_t;

   localparam logic [7:0] K = 8'(SHIFTS_PER_WORD);
   localparam logic [LFSR_BITS-1:0] ONES = '1;

   if (!(LFSR_BITS == 16 || LFSR_BITS == 24 ||
         LFSR_BITS == 31 || LFSR_BITS == 32)) begin : g_bad_n
      $error("LFSR_BITS must be 16, 24, 31 or 32");
   end
   if (OUT_BITS < 1 || OUT_BITS > LFSR_BITS) begin : g_bad_out
      $error("OUT_BITS must be 1..LFSR_BITS");
   end
   if (SHIFTS_PER_WORD < 1 || SHIFTS_PER_WORD > 255) begin : g_bad_k
      $error("SHIFTS_PER_WORD must be 1..255");
   end
   if (SEED == ONES) begin : g_bad_seed
      $error("SEED must not be all-ones");
   end

   logic [LFSR_BITS-1:0] lfsr_q, lfsr_d;
   logic [7:0]           cnt_q, cnt_d;
   state_t               state_q, state_d;
   logic                 valid_q, valid_d;
   logic                 fix_q, fix_d;
   logic                 fb;

   // Tap sets are 1-based register positions; lfsr_q[i-1] holds position i.
   if (LFSR_BITS == 16) begin : g_t16
      assign fb = ~(lfsr_q[15] ^ lfsr_q[14] ^ lfsr_q[12] ^ lfsr_q[3]);
   end else if (LFSR_BITS == 24) begin : g_t24
      assign fb = ~(lfsr_q[23] ^ lfsr_q[22] ^ lfsr_q[21] ^ lfsr_q[16]);
   end else if (LFSR_BITS == 31) begin : g_t31
      assign fb = ~(lfsr_q[30] ^ lfsr_q[27]);
   end else begin : g_t32
      assign fb = ~(lfsr_q[31] ^ lfsr_q[21] ^ lfsr_q[1] ^ lfsr_q[0]);
   end

   logic [LFSR_BITS-1:0] shifted;
   logic [7:0]           cnt_inc;

   always_comb begin
      shifted = {lfsr_q[LFSR_BITS-2:0], fb};
      cnt_inc = cnt_q + 8'd1;
      lfsr_d  = lfsr_q;
      cnt_d   = cnt_q;
      state_d = state_q;
      valid_d = valid_q;
      fix_d   = 1'b0;
      if (seed_load) begin
         cnt_d   = 8'd0;
         state_d = RUN;
         valid_d = 1'b0;
         if (seed_data == ONES) begin
            lfsr_d = SEED;
            fix_d  = 1'b1;
         end else begin
            lfsr_d = seed_data;
         end
      end else if (lfsr_q == ONES) begin
         lfsr_d  = SEED;
         cnt_d   = 8'd0;
         state_d = RUN;
         valid_d = 1'b0;
         fix_d   = 1'b1;
      end else begin
         unique case (state_q)
            RUN: begin
               if (enable) begin
                  lfsr_d = shifted;
                  if (cnt_inc == K) begin
                     cnt_d   = 8'd0;
                     state_d = PRESENT;
                     valid_d = 1'b1;
                  end else begin
                     cnt_d = cnt_inc;
                  end
               end
            end
            PRESENT: begin
               // A held word freezes the register until it is taken.
               if (valid_q && out_ready) begin
                  if (enable) begin
                     lfsr_d = shifted;
                     if (K == 8'd1) begin
                        cnt_d   = 8'd0;
                        state_d = PRESENT;
                        valid_d = 1'b1;
                     end else begin
                        cnt_d   = 8'd1;
                        state_d = RUN;
                        valid_d = 1'b0;
                     end
                  end else begin
                     cnt_d   = 8'd0;
                     state_d = RUN;
                     valid_d = 1'b0;
                  end
               end
            end
            default: begin
               state_d = RUN;
               valid_d = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         lfsr_q  <= SEED;
         cnt_q   <= 8'd0;
         state_q <= RUN;
         valid_q <= 1'b0;
         fix_q   <= 1'b0;
      end else begin
         lfsr_q  <= lfsr_d;
         cnt_q   <= cnt_d;
         state_q <= state_d;
         valid_q <= valid_d;
         fix_q   <= fix_d;
      end
   end

   assign out_data   = lfsr_q[OUT_BITS-1:0];
   assign out_valid  = valid_q;
   assign lockup_fix = fix_q;

endmodule

// File: tb/tb_lfsr_noise_stream.sv
// Bench for lfsr_noise_stream: directed word sequences plus
// randomized streams checked against a behavioural model.
module tb_lfsr_noise_stream;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst [3];
   logic        en  [3];
   logic        sl  [3];
   logic        rdy [3];
   logic [31:0] sd  [3];
   logic        vld [3];
   logic        fix [3];
   logic [15:0] dat [3];

   int checks   = 0;
   int failures = 0;

   localparam logic [30:0] SEED_C = 31'h0ABC_DEF0;

   lfsr_noise_stream #(
      .LFSR_BITS(16), .OUT_BITS(16), .SHIFTS_PER_WORD(1), .SEED(16'h0000)
   ) u_a (
      .clk(clk), .reset(rst[0]), .enable(en[0]), .seed_load(sl[0]),
      .seed_data(sd[0][15:0]), .out_valid(vld[0]), .out_ready(rdy[0]),
      .out_data(dat[0]), .lockup_fix(fix[0])
   );

   lfsr_noise_stream #(
      .LFSR_BITS(16), .OUT_BITS(16), .SHIFTS_PER_WORD(4), .SEED(16'h0000)
   ) u_b (
      .clk(clk), .reset(rst[1]), .enable(en[1]), .seed_load(sl[1]),
      .seed_data(sd[1][15:0]), .out_valid(vld[1]), .out_ready(rdy[1]),
      .out_data(dat[1]), .lockup_fix(fix[1])
   );

   lfsr_noise_stream #(
      .LFSR_BITS(31), .OUT_BITS(16), .SHIFTS_PER_WORD(1), .SEED(SEED_C)
   ) u_c (
      .clk(clk), .reset(rst[2]), .enable(en[2]), .seed_load(sl[2]),
      .seed_data(sd[2][30:0]), .out_valid(vld[2]), .out_ready(rdy[2]),
      .out_data(dat[2]), .lockup_fix(fix[2])
   );

   function automatic logic [31:0] all_ones(input int n);
      return (n == 32) ? 32'hFFFF_FFFF : ((32'd1 << n) - 32'd1);
   endfunction

   // One register shift: new bit is XNOR of the tap positions.
   function automatic logic [31:0] ref_step(input int n, input logic [31:0] v);
      logic [31:0] taps;
      logic        nb;
      case (n)
         16:      taps = (32'd1 << 15) | (32'd1 << 14) | (32'd1 << 12) | (32'd1 << 3);
         24:      taps = (32'd1 << 23) | (32'd1 << 22) | (32'd1 << 21) | (32'd1 << 16);
         31:      taps = (32'd1 << 30) | (32'd1 << 27);
         default: taps = (32'd1 << 31) | (32'd1 << 21) | (32'd1 << 1) | 32'd1;
      endcase
      nb = ~(^(v & taps));
      return ((v << 1) | {31'd0, nb}) & all_ones(n);
   endfunction

   function automatic logic [31:0] ref_adv(input int n, input logic [31:0] v, input int k);
      logic [31:0] r;
      r = v;
      for (int i = 0; i < k; i++) r = ref_step(n, r);
      return r;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", name, got, exp);
      end
   endtask

   task automatic test_reset();
      logic [15:0] exp_seed [3];
      logic [31:0] sc;
      sc = {1'b0, SEED_C};
      exp_seed[0] = 16'h0000;
      exp_seed[1] = 16'h0000;
      exp_seed[2] = sc[15:0];
      for (int i = 0; i < 3; i++) begin
         rst[i] = 1'b1; en[i] = 1'b0; sl[i] = 1'b0; rdy[i] = 1'b0; sd[i] = '0;
      end
      tick();
      tick();
      for (int i = 0; i < 3; i++) rst[i] = 1'b0;
      for (int i = 0; i < 3; i++) begin
         if (vld[i] !== 1'b0) begin
            failures++; $display("FAIL reset_valid[%0d] got=%b exp=0", i, vld[i]);
         end
         checks++;
         if (dat[i] !== exp_seed[i]) begin
            failures++; $display("FAIL reset_data[%0d] got=%h exp=%h", i, dat[i], exp_seed[i]);
         end
         checks++;
         if (fix[i] !== 1'b0) begin
            failures++; $display("FAIL reset_fix[%0d] got=%b exp=0", i, fix[i]);
         end
         checks++;
      end
   endtask

   task automatic test_k1_sequence();
      logic [15:0] exp_w [5];
      exp_w = '{16'h0001, 16'h0003, 16'h0007, 16'h000F, 16'h001E};
      en[0] = 1'b1; rdy[0] = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         checks++;
         if (vld[0] !== 1'b1 || dat[0] !== exp_w[i]) begin
            failures++;
            $display("FAIL k1_word%0d got=%b/%h exp=1/%h", i, vld[0], dat[0], exp_w[i]);
         end
      end
      en[0] = 1'b0; rdy[0] = 1'b0;
   endtask

   task automatic test_k4_latency();
      en[1] = 1'b1; rdy[1] = 1'b1;
      for (int e = 1; e <= 8; e++) begin
         tick();
         checks++;
         if (vld[1] !== (e == 4 || e == 8)) begin
            failures++;
            $display("FAIL k4_valid_edge%0d got=%b exp=%b", e, vld[1], (e == 4 || e == 8));
         end
         if (e == 4) begin
            checks++;
            if (dat[1] !== 16'h000F) begin
               failures++; $display("FAIL k4_word0 got=%h exp=000f", dat[1]);
            end
         end
         if (e == 8) begin
            checks++;
            if (dat[1] !== 16'h00F0) begin
               failures++; $display("FAIL k4_word1 got=%h exp=00f0", dat[1]);
            end
         end
      end
      en[1] = 1'b0; rdy[1] = 1'b0;
   endtask

   task automatic test_backpressure();
      rst[0] = 1'b1; en[0] = 1'b0; rdy[0] = 1'b0;
      tick();
      rst[0] = 1'b0; en[0] = 1'b1;
      tick();
      for (int i = 0; i < 10; i++) begin
         tick();
         checks++;
         if (vld[0] !== 1'b1 || dat[0] !== 16'h0001) begin
            failures++;
            $display("FAIL bp_hold%0d got=%b/%h exp=1/0001", i, vld[0], dat[0]);
         end
      end
      rdy[0] = 1'b1;
      tick();
      rdy[0] = 1'b0;
      checks++;
      if (vld[0] !== 1'b1 || dat[0] !== 16'h0003) begin
         failures++; $display("FAIL bp_next got=%b/%h exp=1/0003", vld[0], dat[0]);
      end
      tick();
      tick();
      checks++;
      if (vld[0] !== 1'b1 || dat[0] !== 16'h0003) begin
         failures++; $display("FAIL bp_hold_again got=%b/%h exp=1/0003", vld[0], dat[0]);
      end
   endtask

   task automatic test_seed_load();
      logic [31:0] nx;
      nx = ref_step(16, 32'h1234);
      sl[0] = 1'b1; sd[0] = 32'h1234; en[0] = 1'b1; rdy[0] = 1'b0;
      tick();
      sl[0] = 1'b0;
      checks++;
      if (vld[0] !== 1'b0 || dat[0] !== 16'h1234) begin
         failures++; $display("FAIL seed_load got=%b/%h exp=0/1234", vld[0], dat[0]);
      end
      rdy[0] = 1'b1;
      tick();
      checks++;
      if (vld[0] !== 1'b1 || dat[0] !== nx[15:0]) begin
         failures++; $display("FAIL seed_next got=%b/%h exp=1/%h", vld[0], dat[0], nx[15:0]);
      end
      en[0] = 1'b0;
      tick();
      checks++;
      if (vld[0] !== 1'b0 || dat[0] !== nx[15:0]) begin
         failures++; $display("FAIL take_paused got=%b/%h exp=0/%h", vld[0], dat[0], nx[15:0]);
      end
      rdy[0] = 1'b0;
   endtask

   task automatic test_lockup();
      en[0] = 1'b0; rdy[0] = 1'b0;
      sl[0] = 1'b1; sd[0] = 32'h0000_FFFF;
      tick();
      sl[0] = 1'b0;
      checks++;
      if (fix[0] !== 1'b1 || dat[0] !== 16'h0000 || vld[0] !== 1'b0) begin
         failures++;
         $display("FAIL ones_seed got=fix%b/%h/v%b exp=fix1/0000/v0", fix[0], dat[0], vld[0]);
      end
      tick();
      checks++;
      if (fix[0] !== 1'b0) begin
         failures++; $display("FAIL ones_seed_pulse got=%b exp=0", fix[0]);
      end
      force u_a.lfsr_q = 16'hFFFF;
      #1;
      release u_a.lfsr_q;
      tick();
      checks++;
      if (fix[0] !== 1'b1 || dat[0] !== 16'h0000 || vld[0] !== 1'b0) begin
         failures++;
         $display("FAIL upset_fix got=fix%b/%h/v%b exp=fix1/0000/v0", fix[0], dat[0], vld[0]);
      end
      tick();
      checks++;
      if (fix[0] !== 1'b0 || dat[0] !== 16'h0000) begin
         failures++; $display("FAIL upset_pulse got=fix%b/%h exp=fix0/0000", fix[0], dat[0]);
      end
   endtask

   // Model: a word is offered after K enabled shifts; an offered word
   // that is not taken blocks all shifting; every taken word is exactly
   // K shifts after the previous one in the stream.
   task automatic test_random(input int idx, input int n, input int k,
                              input logic [31:0] seed, input int cycles);
      logic [31:0] m, nxt, v, all;
      int          done;
      logic        pres, fx, e, r, ld, rs, pv;
      logic [15:0] pd;
      all = all_ones(n);
      rst[idx] = 1'b1; en[idx] = 1'b0; sl[idx] = 1'b0; rdy[idx] = 1'b0;
      tick();
      rst[idx] = 1'b0;
      m = seed; done = 0; pres = 1'b0; fx = 1'b0;
      nxt = ref_adv(n, seed, k);
      checks++;
      if (vld[idx] !== 1'b0 || dat[idx] !== seed[15:0] || fix[idx] !== 1'b0) begin
         failures++;
         $display("FAIL rnd%0d_reset got=%b/%h exp=0/%h", idx, vld[idx], dat[idx], seed[15:0]);
      end
      pv = vld[idx]; pd = dat[idx];
      for (int c = 0; c < cycles; c++) begin
         e  = ($urandom_range(0, 3) != 0);
         r  = ($urandom_range(0, 3) != 0);
         ld = ($urandom_range(0, 149) == 0);
         rs = (c == cycles / 2);
         v  = $urandom & all;
         if ($urandom_range(0, 3) == 0) v = all;
         en[idx] = e; rdy[idx] = r; sl[idx] = ld; sd[idx] = v; rst[idx] = rs;
         tick();
         if (!rs && pv && r) begin
            checks++;
            if (pd !== nxt[15:0]) begin
               failures++;
               $display("FAIL rnd%0d_word c=%0d got=%h exp=%h", idx, c, pd, nxt[15:0]);
            end
            nxt = ref_adv(n, nxt, k);
         end
         fx = 1'b0;
         if (rs) begin
            m = seed; done = 0; pres = 1'b0;
            nxt = ref_adv(n, m, k);
         end else if (ld) begin
            m = (v == all) ? seed : v;
            fx = (v == all);
            done = 0; pres = 1'b0;
            nxt = ref_adv(n, m, k);
         end else if (!(pres && !r)) begin
            if (e) begin
               m = ref_step(n, m);
               done++;
               pres = (done == k);
               if (pres) done = 0;
            end else begin
               pres = 1'b0;
            end
         end
         checks++;
         if (vld[idx] !== pres || dat[idx] !== m[15:0] || fix[idx] !== fx) begin
            failures++;
            $display("FAIL rnd%0d_cycle c=%0d got=v%b/%h/f%b exp=v%b/%h/f%b",
                     idx, c, vld[idx], dat[idx], fix[idx], pres, m[15:0], fx);
         end
         pv = vld[idx]; pd = dat[idx];
      end
      en[idx] = 1'b0; rdy[idx] = 1'b0; sl[idx] = 1'b0; rst[idx] = 1'b0;
   endtask

   initial begin
      test_reset();
      test_k1_sequence();
      test_k4_latency();
      test_backpressure();
      test_seed_load();
      test_lockup();
      test_random(1, 16, 4, 32'h0000_0000, 4000);
      test_random(2, 31, 1, {1'b0, SEED_C}, 30000);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
